// File: rtl/tcm_boot_loader.sv
// Boot loader: packs a little-endian host byte stream into 32-bit words, writes them to TCM
// over the mem_d port, reads them back, and releases the core only when the checksums agree.
module tcm_boot_loader #(
  parameter int               TAG_W  = 11,
  parameter int               LEN_W  = 16,
  parameter logic [TAG_W-1:0] TAG_ID = 11'h7FF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [31:0]       base_addr_i,
  input  logic [LEN_W-1:0]  length_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic [31:0]       mem_d_addr_o,
  output logic [31:0]       mem_d_data_wr_o,
  output logic              mem_d_rd_o,
  output logic [3:0]        mem_d_wr_o,
  output logic              mem_d_cacheable_o,
  output logic [TAG_W-1:0]  mem_d_req_tag_o,
  output logic              mem_d_invalidate_o,
  output logic              mem_d_writeback_o,
  output logic              mem_d_flush_o,
  input  logic [31:0]       mem_d_data_rd_i,
  input  logic              mem_d_accept_i,
  input  logic              mem_d_ack_i,
  input  logic              mem_d_error_i,
  input  logic [TAG_W-1:0]  mem_d_resp_tag_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              fail_o,
  output logic              core_rst_o,
  output logic [3:0]        dbg_state_o
);

  // Handshakes: a stream byte moves on a posedge where byte_valid_i && byte_ready_o; a mem_d
  // request is held unchanged until the posedge where mem_d_accept_i=1; a response is the
  // posedge where mem_d_ack_i=1 with a matching tag (may coincide with the accept edge).
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_COLLECT = 4'd1,
    S_WR_REQ  = 4'd2,
    S_WR_WAIT = 4'd3,
    S_RD_REQ  = 4'd4,
    S_RD_WAIT = 4'd5,
    S_CHECK   = 4'd6,
    S_DONE    = 4'd7,
    S_FAIL    = 4'd8
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        base_q, base_d;
  logic [31:0]        addr_q, addr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [31:0]        word_q, word_d;
  logic [31:0]        wsum_q, wsum_d;
  logic [31:0]        rsum_q, rsum_d;

  logic               byte_ready_q, byte_ready_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        mem_data_q, mem_data_d;
  logic               mem_rd_q, mem_rd_d;
  logic [3:0]         mem_wr_q, mem_wr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               fail_q, fail_d;
  logic               core_rst_q, core_rst_d;

  logic               ack_ok;
  logic               byte_fire;
  logic               wr_ack;
  logic               rd_ack;
  logic               unused_addr_lsb;

  assign unused_addr_lsb = ^base_addr_i[1:0];

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    addr_d     = addr_q;
    len_d      = len_q;
    rem_d      = rem_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    wsum_d     = wsum_q;
    rsum_d     = rsum_q;

    ack_ok    = mem_d_ack_i && (mem_d_resp_tag_i == TAG_ID);
    byte_fire = byte_valid_i && byte_ready_q;
    // An ack landing on the accept edge completes the transaction without visiting *_WAIT.
    wr_ack = ack_ok && ((state_q == S_WR_WAIT) || ((state_q == S_WR_REQ) && mem_d_accept_i));
    rd_ack = ack_ok && ((state_q == S_RD_WAIT) || ((state_q == S_RD_REQ) && mem_d_accept_i));

    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start_i) begin
          base_d     = {base_addr_i[31:2], 2'b00};
          addr_d     = {base_addr_i[31:2], 2'b00};
          len_d      = length_i;
          rem_d      = length_i;
          byte_idx_d = 2'd0;
          word_d     = 32'h0;
          wsum_d     = 32'h0;
          rsum_d     = 32'h0;
          state_d    = (length_i == '0) ? S_DONE : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (byte_fire) begin
          case (byte_idx_q)
            2'd0:    word_d[7:0]   = byte_data_i;
            2'd1:    word_d[15:8]  = byte_data_i;
            2'd2:    word_d[23:16] = byte_data_i;
            default: word_d[31:24] = byte_data_i;
          endcase
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            wsum_d  = wsum_q + {byte_data_i, word_q[23:0]};
            state_d = S_WR_REQ;
          end
        end
      end
      S_WR_REQ: begin
        if (mem_d_accept_i) state_d = S_WR_WAIT;
      end
      S_RD_REQ: begin
        if (mem_d_accept_i) state_d = S_RD_WAIT;
      end
      S_CHECK: begin
        state_d = (rsum_q == wsum_q) ? S_DONE : S_FAIL;
      end
      default: begin
      end
    endcase

    if (wr_ack || rd_ack) begin
      if (mem_d_error_i) begin
        state_d = S_FAIL;
      end else begin
        addr_d = addr_q + 32'd4;
        rem_d  = rem_q - LEN_W'(1);
        if (rd_ack) rsum_d = rsum_q + mem_d_data_rd_i;
        if (rem_q == LEN_W'(1)) begin
          addr_d  = base_q;
          rem_d   = len_q;
          state_d = wr_ack ? S_RD_REQ : S_CHECK;
        end else begin
          state_d = wr_ack ? S_COLLECT : S_RD_REQ;
        end
      end
    end

    // Outputs are registered from the next state so they change on the same edge as the FSM.
    byte_ready_d = (state_d == S_COLLECT);
    mem_addr_d   = ((state_d == S_WR_REQ) || (state_d == S_RD_REQ)) ? addr_d : 32'h0;
    mem_data_d   = (state_d == S_WR_REQ) ? word_d : 32'h0;
    mem_wr_d     = (state_d == S_WR_REQ) ? 4'hF : 4'h0;
    mem_rd_d     = (state_d == S_RD_REQ);
    busy_d       = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_FAIL));
    done_d       = (state_d == S_DONE);
    fail_d       = (state_d == S_FAIL);
    core_rst_d   = (state_d != S_DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      base_q       <= 32'h0;
      addr_q       <= 32'h0;
      len_q        <= '0;
      rem_q        <= '0;
      byte_idx_q   <= 2'd0;
      word_q       <= 32'h0;
      wsum_q       <= 32'h0;
      rsum_q       <= 32'h0;
      byte_ready_q <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_data_q   <= 32'h0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 4'h0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      core_rst_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      rem_q        <= rem_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      wsum_q       <= wsum_d;
      rsum_q       <= rsum_d;
      byte_ready_q <= byte_ready_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      core_rst_q   <= core_rst_d;
    end
  end

  assign byte_ready_o       = byte_ready_q;
  assign mem_d_addr_o       = mem_addr_q;
  assign mem_d_data_wr_o    = mem_data_q;
  assign mem_d_rd_o         = mem_rd_q;
  assign mem_d_wr_o         = mem_wr_q;
  assign mem_d_cacheable_o  = 1'b0;
  assign mem_d_req_tag_o    = TAG_ID;
  assign mem_d_invalidate_o = 1'b0;
  assign mem_d_writeback_o  = 1'b0;
  assign mem_d_flush_o      = 1'b0;
  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign fail_o             = fail_q;
  assign core_rst_o         = core_rst_q;
  assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_tcm_boot_loader.sv
// Bench for tcm_boot_loader: table of load scenarios run against a behavioural TCM responder,
// plus a hand-written reset-in-flight / zero-length sequence.
module tb_tcm_boot_loader;
  localparam int          TAG_W  = 11;
  localparam int          LEN_W  = 16;
  localparam logic [10:0] TAG_ID = 11'h7FF;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_i;
  logic [31:0]       base_addr_i;
  logic [LEN_W-1:0]  length_i;
  logic              byte_valid_i;
  logic [7:0]        byte_data_i;
  logic              byte_ready_o;
  logic [31:0]       mem_d_addr_o;
  logic [31:0]       mem_d_data_wr_o;
  logic              mem_d_rd_o;
  logic [3:0]        mem_d_wr_o;
  logic              mem_d_cacheable_o;
  logic [TAG_W-1:0]  mem_d_req_tag_o;
  logic              mem_d_invalidate_o;
  logic              mem_d_writeback_o;
  logic              mem_d_flush_o;
  logic [31:0]       mem_d_data_rd_i;
  logic              mem_d_accept_i;
  logic              mem_d_ack_i;
  logic              mem_d_error_i;
  logic [TAG_W-1:0]  mem_d_resp_tag_i;
  logic              busy_o;
  logic              done_o;
  logic              fail_o;
  logic              core_rst_o;
  logic [3:0]        dbg_state_o;

  always #5 clk = ~clk;

  tcm_boot_loader #(.TAG_W(TAG_W), .LEN_W(LEN_W), .TAG_ID(TAG_ID)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .base_addr_i(base_addr_i),
    .length_i(length_i), .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i),
    .byte_ready_o(byte_ready_o), .mem_d_addr_o(mem_d_addr_o),
    .mem_d_data_wr_o(mem_d_data_wr_o), .mem_d_rd_o(mem_d_rd_o), .mem_d_wr_o(mem_d_wr_o),
    .mem_d_cacheable_o(mem_d_cacheable_o), .mem_d_req_tag_o(mem_d_req_tag_o),
    .mem_d_invalidate_o(mem_d_invalidate_o), .mem_d_writeback_o(mem_d_writeback_o),
    .mem_d_flush_o(mem_d_flush_o), .mem_d_data_rd_i(mem_d_data_rd_i),
    .mem_d_accept_i(mem_d_accept_i), .mem_d_ack_i(mem_d_ack_i),
    .mem_d_error_i(mem_d_error_i), .mem_d_resp_tag_i(mem_d_resp_tag_i),
    .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o), .core_rst_o(core_rst_o),
    .dbg_state_o(dbg_state_o)
  );

  typedef struct {
    logic [31:0] base;
    int          len;
    logic [7:0]  seed;
    int          acc_delay;
    int          err_rd;
    bit          corrupt;
    bit          same;
    bit          stray;
    bit          exp_done;
    int          exp_wr;
    int          exp_rd;
  } vec_t;

  vec_t vecs[7];

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_waddr_q[$];
  logic [31:0] exp_raddr_q[$];
  logic [31:0] wlog_q[$];
  logic [31:0] mem [logic [31:0]];

  int          cfg_acc_delay, cfg_err_rd;
  bit          cfg_corrupt, cfg_same, cfg_stray, hold_ack, inject_stale;
  bit          pend, pend_err, stray_now;
  logic [31:0] pend_data, r_data;
  bit          r_err;
  int          n_wr, n_rd, n_txn, wait_cnt;
  int          unstable, req_in_fail, bad_ready, bad_side;
  logic [31:0] h_addr, h_data;
  logic [3:0]  h_wr;
  logic        h_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Behavioural TCM responder: drives inputs on negedge, DUT samples them on posedge.
  always @(negedge clk) begin
    mem_d_accept_i   = 1'b0;
    mem_d_ack_i      = 1'b0;
    mem_d_error_i    = 1'b0;
    mem_d_resp_tag_i = TAG_ID;
    mem_d_data_rd_i  = 32'h0;
    if (!rst) begin
      if (fail_o && (mem_d_rd_o || mem_d_wr_o != 4'h0)) req_in_fail++;
      if (byte_ready_o && (mem_d_rd_o || mem_d_wr_o != 4'h0 || done_o || fail_o)) bad_ready++;
      if (mem_d_req_tag_o != TAG_ID || mem_d_cacheable_o || mem_d_invalidate_o ||
          mem_d_writeback_o || mem_d_flush_o) bad_side++;
      if (inject_stale) begin
        mem_d_ack_i = 1'b1; mem_d_error_i = 1'b1; mem_d_data_rd_i = 32'hBAD0_0BAD;
        inject_stale = 1'b0;
      end else if (pend) begin
        if (hold_ack) begin
        end else if (stray_now) begin
          mem_d_ack_i = 1'b1; mem_d_resp_tag_i = 11'h001; mem_d_error_i = 1'b1;
          mem_d_data_rd_i = 32'hDEAD_BEEF; stray_now = 1'b0;
        end else begin
          mem_d_ack_i = 1'b1; mem_d_error_i = pend_err; mem_d_data_rd_i = pend_data; pend = 1'b0;
        end
      end else if (mem_d_rd_o || mem_d_wr_o != 4'h0) begin
        if (n_txn == 0) begin
          if (wait_cnt == 0) begin
            h_addr = mem_d_addr_o; h_data = mem_d_data_wr_o; h_wr = mem_d_wr_o; h_rd = mem_d_rd_o;
          end else if (h_addr != mem_d_addr_o || h_data != mem_d_data_wr_o ||
                       h_wr != mem_d_wr_o || h_rd != mem_d_rd_o) begin
            unstable++;
          end
        end
        if (n_txn == 0 && wait_cnt < cfg_acc_delay) begin
          wait_cnt++;
        end else begin
          mem_d_accept_i = 1'b1;
          n_txn++;
          if (mem_d_wr_o != 4'h0) begin
            n_wr++;
            check("wr_strobe", mem_d_wr_o, 4'hF);
            check("wr_no_rd", mem_d_rd_o, 1'b0);
            if (exp_q.size() == 0) check("wr_extra_words", exp_q.size(), 1);
            else begin
              check("wr_data", mem_d_data_wr_o, exp_q.pop_front());
              check("wr_addr", mem_d_addr_o, exp_waddr_q.pop_front());
            end
            mem[mem_d_addr_o] = mem_d_data_wr_o;
            wlog_q.push_back(mem_d_data_wr_o);
            r_data = 32'h0; r_err = 1'b0;
          end else begin
            n_rd++;
            if (exp_raddr_q.size() == 0) check("rd_extra_words", exp_raddr_q.size(), 1);
            else check("rd_addr", mem_d_addr_o, exp_raddr_q.pop_front());
            r_data = mem.exists(mem_d_addr_o) ? mem[mem_d_addr_o] : 32'h0;
            if (cfg_corrupt && n_rd == 1) r_data = r_data ^ 32'h1;
            r_err = ((n_rd - 1) == cfg_err_rd);
          end
          if (cfg_same && !(cfg_stray && n_txn == 1)) begin
            mem_d_ack_i = 1'b1; mem_d_error_i = r_err; mem_d_data_rd_i = r_data;
          end else begin
            pend = 1'b1; pend_err = r_err; pend_data = r_data;
            stray_now = cfg_stray && (n_txn == 1);
          end
        end
      end
    end
  end

  task automatic prep(input logic [31:0] base, input int len, input logic [7:0] seed);
    logic [31:0] a;
    logic [7:0]  b0, b1, b2, b3;
    exp_q.delete(); exp_waddr_q.delete(); exp_raddr_q.delete(); wlog_q.delete(); mem.delete();
    n_wr = 0; n_rd = 0; n_txn = 0; wait_cnt = 0; pend = 1'b0; stray_now = 1'b0;
    unstable = 0; req_in_fail = 0;
    a = {base[31:2], 2'b00};
    for (int i = 0; i < len; i++) begin
      b0 = seed + 8'(4 * i);
      b1 = seed + 8'(4 * i + 1);
      b2 = seed + 8'(4 * i + 2);
      b3 = seed + 8'(4 * i + 3);
      exp_q.push_back({b3, b2, b1, b0});
      exp_waddr_q.push_back(a);
      exp_raddr_q.push_back(a);
      a = a + 32'd4;
    end
  endtask

  task automatic pulse_start(input logic [31:0] base, input int len);
    start_i = 1'b1; base_addr_i = base; length_i = LEN_W'(len);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // A second start with length 0 is pulsed mid-collection; a busy loader must ignore it.
  task automatic send_bytes(input logic [7:0] seed, input int len);
    int cnt;
    for (int k = 0; k < 4 * len; k++) begin
      byte_valid_i = 1'b1;
      byte_data_i  = seed + 8'(k);
      if (k == 1) begin start_i = 1'b1; length_i = '0; end
      cnt = 0;
      while (!byte_ready_o && cnt < 500) begin
        @(negedge clk);
        start_i = 1'b0;
        cnt++;
      end
      if (cnt >= 500) begin
        check("byte_ready_timeout", byte_ready_o, 1'b1);
        break;
      end
      @(negedge clk);
      start_i = 1'b0;
    end
    byte_valid_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, mem_d_addr_o, 32'h0);
    check({tag, "_wdata"}, mem_d_data_wr_o, 32'h0);
    check({tag, "_rd"}, mem_d_rd_o, 1'b0);
    check({tag, "_wr"}, mem_d_wr_o, 4'h0);
    check({tag, "_byte_ready"}, byte_ready_o, 1'b0);
    check({tag, "_busy"}, busy_o, 1'b0);
    check({tag, "_done"}, done_o, 1'b0);
    check({tag, "_fail"}, fail_o, 1'b0);
    check({tag, "_core_rst"}, core_rst_o, 1'b1);
    check({tag, "_state"}, dbg_state_o, 4'd0);
  endtask

  task automatic run_vec(input int vi);
    vec_t v;
    int   cnt;
    v = vecs[vi];
    prep(v.base, v.len, v.seed);
    cfg_acc_delay = v.acc_delay; cfg_err_rd = v.err_rd; cfg_corrupt = v.corrupt;
    cfg_same = v.same; cfg_stray = v.stray; hold_ack = 1'b0;
    pulse_start(v.base, v.len);
    send_bytes(v.seed, v.len);
    cnt = 0;
    while (!(done_o || fail_o) && cnt < 3000) begin
      @(negedge clk);
      cnt++;
    end
    check($sformatf("v%0d_done", vi), done_o, v.exp_done);
    check($sformatf("v%0d_fail", vi), fail_o, !v.exp_done);
    check($sformatf("v%0d_core_rst", vi), core_rst_o, !v.exp_done);
    check($sformatf("v%0d_busy", vi), busy_o, 1'b0);
    repeat (8) @(negedge clk);
    check($sformatf("v%0d_n_writes", vi), n_wr, v.exp_wr);
    check($sformatf("v%0d_n_reads", vi), n_rd, v.exp_rd);
    check($sformatf("v%0d_req_after_fail", vi), req_in_fail, 0);
    check($sformatf("v%0d_req_unstable", vi), unstable, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int txn_snap;
    //            base          len seed   acc err corr same stray done wr rd
    vecs[0] = '{32'h0000_0100, 2, 8'h01, 0, -1, 1'b0, 1'b0, 1'b0, 1'b1, 2, 2};
    vecs[1] = '{32'h0000_0200, 3, 8'h10, 5, -1, 1'b0, 1'b0, 1'b0, 1'b1, 3, 3};
    vecs[2] = '{32'h0000_0300, 3, 8'h20, 0,  1, 1'b0, 1'b0, 1'b0, 1'b0, 3, 2};
    vecs[3] = '{32'h0000_0100, 2, 8'h01, 0, -1, 1'b1, 1'b0, 1'b0, 1'b0, 2, 2};
    vecs[4] = '{32'h0000_0400, 3, 8'h30, 0, -1, 1'b0, 1'b1, 1'b1, 1'b1, 3, 3};
    vecs[5] = '{32'hFFFF_FFF8, 3, 8'hF0, 0, -1, 1'b0, 1'b0, 1'b0, 1'b1, 3, 3};
    vecs[6] = '{32'h0000_0503, 1, 8'h55, 0, -1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1};

    rst = 1'b1; start_i = 1'b0; base_addr_i = 32'h0; length_i = '0;
    byte_valid_i = 1'b0; byte_data_i = 8'h0;
    hold_ack = 1'b0; inject_stale = 1'b0; bad_ready = 0; bad_side = 0;
    cfg_acc_delay = 0; cfg_err_rd = -1; cfg_corrupt = 1'b0; cfg_same = 1'b0; cfg_stray = 1'b0;
    pend = 1'b0; stray_now = 1'b0; n_txn = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_vec(i);
      if (i == 0) begin
        check("v0_word0", wlog_q.size() > 0 ? wlog_q[0] : 32'hX, 32'h0403_0201);
        check("v0_word1", wlog_q.size() > 1 ? wlog_q[1] : 32'hX, 32'h0807_0605);
      end
    end

    // Reset while a write waits for its ack, then a stale ack, then a zero-length load.
    prep(32'h0000_0600, 2, 8'h60);
    cfg_acc_delay = 0; cfg_err_rd = -1; cfg_corrupt = 1'b0; cfg_same = 1'b0; cfg_stray = 1'b0;
    hold_ack = 1'b1;
    pulse_start(32'h0000_0600, 2);
    send_bytes(8'h60, 1);
    cnt = 0;
    while (n_wr == 0 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    @(negedge clk);
    check("wr_wait_busy", busy_o, 1'b1);
    check("wr_wait_state", dbg_state_o, 4'd3);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    pend = 1'b0; stray_now = 1'b0; hold_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    inject_stale = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("stale_ack");
    txn_snap = n_txn;
    pulse_start(32'h0000_0800, 0);
    check("len0_done", done_o, 1'b1);
    check("len0_core_rst", core_rst_o, 1'b0);
    check("len0_busy", busy_o, 1'b0);
    repeat (4) @(negedge clk);
    check("len0_no_traffic", n_txn, txn_snap);
    check("len0_done_held", done_o, 1'b1);

    check("byte_ready_outside_collect", bad_ready, 0);
    check("tied_outputs", bad_side, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
